vx_writeback_arbiter: RTL and testbench

VX_WRITEBACK_ARBITER -- requirements
Module: VX_writeback_arbiter

---
 rtl/vx_gpu_pkg.sv | 20 ++
 rtl/vx_rr_arbiter.sv | 74 +++++++
 rtl/vx_writeback_arbiter.sv | 135 +++++++++++++
 tb/tb_vx_writeback_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vx_gpu_pkg.sv
// Shared commit-record widths, writeback channel indices and arbiter lock states.
package vx_gpu_pkg;

    localparam int PC_BITS   = 32;
    localparam int RD_BITS   = 5;
    localparam int DATA_BITS = 32;

    localparam int CH_ALU = 0;
    localparam int CH_LD  = 1;
    localparam int CH_ST  = 2;
    localparam int CH_CSR = 3;
    localparam int CH_FPU = 4;
    localparam int CH_GPU = 5;

    typedef enum logic {
        ARB_OPEN   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/vx_rr_arbiter.sv
// Round-robin arbiter; the priority pointer moves only when an eop beat is accepted.
// state      | meaning
// ARB_OPEN   | round-robin from ptr among current requests
// ARB_LOCKED | grant pinned to lock_idx until that channel's eop beat fires
module vx_rr_arbiter
    import vx_gpu_pkg::*;
#(
    parameter int NUM_REQS    = 6,
    parameter bit LOCK_ENABLE = 1'b1,
    localparam int IW         = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_REQS-1:0] requests,
    input  logic                fire,
    input  logic                fire_eop,
    output logic                grant_valid,
    output logic [NUM_REQS-1:0] grant_onehot,
    output logic [IW-1:0]       grant_index
);

    arb_state_e    state, state_next;
    logic [IW-1:0] ptr, ptr_next;
    logic [IW-1:0] lock_idx, lock_idx_next;
    logic [IW-1:0] cand;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ARB_OPEN;
            ptr      <= '0;
            lock_idx <= '0;
        end else begin
            state    <= state_next;
            ptr      <= ptr_next;
            lock_idx <= lock_idx_next;
        end
    end

    always_comb begin
        state_next    = state;
        ptr_next      = ptr;
        lock_idx_next = lock_idx;
        cand          = '0;
        grant_index   = lock_idx;
        grant_valid   = 1'b0;

        if (state == ARB_LOCKED) begin
            grant_valid = requests[lock_idx];
        end else begin
            grant_valid = |requests;
            grant_index = ptr;
            // Descending scan so the requester closest to ptr is the last (winning) write.
            for (int k = NUM_REQS - 1; k >= 0; k--) begin
                cand = IW'((int'(ptr) + k) % NUM_REQS);
                if (requests[cand]) begin
                    grant_index = cand;
                end
            end
        end

        if (fire) begin
            if (fire_eop) begin
                state_next = ARB_OPEN;
                ptr_next   = (grant_index == IW'(NUM_REQS - 1)) ? '0 : grant_index + IW'(1);
            end else if (LOCK_ENABLE) begin
                state_next    = ARB_LOCKED;
                lock_idx_next = grant_index;
            end
        end

        grant_onehot = grant_valid ? (NUM_REQS'(1) << grant_index) : '0;
    end

endmodule

// File: rtl/vx_writeback_arbiter.sv
// Merges per-unit commit streams into one registered writeback port and
// counts lanes retired by eop beats from every channel, writeback or not.
module vx_writeback_arbiter
    import vx_gpu_pkg::*;
#(
    parameter int NUM_CHANNELS = 6,
    parameter int NUM_THREADS  = 4,
    parameter int NW_BITS      = 2,
    parameter int LOCK_PACKETS = 1,
    localparam int CNT_BITS    = $clog2(NUM_CHANNELS * NUM_THREADS + 1)
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic [NUM_CHANNELS-1:0]                     in_valid,
    input  logic [NUM_CHANNELS-1:0]                     in_wb,
    input  logic [NUM_CHANNELS*NW_BITS-1:0]             in_wid,
    input  logic [NUM_CHANNELS*NUM_THREADS-1:0]         in_tmask,
    input  logic [NUM_CHANNELS*PC_BITS-1:0]             in_pc,
    input  logic [NUM_CHANNELS*RD_BITS-1:0]             in_rd,
    input  logic [NUM_CHANNELS*NUM_THREADS*DATA_BITS-1:0] in_data,
    input  logic [NUM_CHANNELS-1:0]                     in_eop,
    output logic [NUM_CHANNELS-1:0]                     in_ready,
    output logic                                        wb_valid,
    output logic [NW_BITS-1:0]                          wb_wid,
    output logic [NUM_THREADS-1:0]                      wb_tmask,
    output logic [PC_BITS-1:0]                          wb_pc,
    output logic [RD_BITS-1:0]                          wb_rd,
    output logic [NUM_THREADS*DATA_BITS-1:0]            wb_data,
    output logic                                        wb_eop,
    input  logic                                        wb_ready,
    output logic                                        cmt_valid,
    output logic [CNT_BITS-1:0]                         cmt_count
);

    localparam int IW     = $clog2(NUM_CHANNELS);
    localparam int LEAVES = 1 << $clog2(NUM_CHANNELS);
    localparam int LW     = NUM_THREADS * DATA_BITS;

    logic                    grant_valid;
    logic [NUM_CHANNELS-1:0] grant_onehot;
    logic [IW-1:0]           grant_index;
    logic                    pipe_ready;
    logic                    grant_fire;
    logic [NUM_CHANNELS-1:0] cmt_fire;

    logic [NW_BITS-1:0]      sel_wid;
    logic [NUM_THREADS-1:0]  sel_tmask;
    logic [PC_BITS-1:0]      sel_pc;
    logic [RD_BITS-1:0]      sel_rd;
    logic [LW-1:0]           sel_data;
    logic                    sel_eop;

    logic [CNT_BITS-1:0]     tree [1:2*LEAVES-1];

    vx_rr_arbiter #(
        .NUM_REQS    (NUM_CHANNELS),
        .LOCK_ENABLE (LOCK_PACKETS != 0)
    ) u_rr_arbiter (
        .clk          (clk),
        .reset        (reset),
        .requests     (in_valid & in_wb),
        .fire         (grant_fire),
        .fire_eop     (sel_eop),
        .grant_valid  (grant_valid),
        .grant_onehot (grant_onehot),
        .grant_index  (grant_index)
    );

    // Ready depends only on the output register, grant and reset; reset blocks wb accepts.
    assign pipe_ready = ~wb_valid | wb_ready;
    assign grant_fire = reset & grant_valid & pipe_ready;
    assign in_ready   = ~in_wb | ({NUM_CHANNELS{reset & pipe_ready}} & grant_onehot);
    assign cmt_fire   = in_valid & in_ready & in_eop;

    always_comb begin
        sel_wid   = '0;
        sel_tmask = '0;
        sel_pc    = '0;
        sel_rd    = '0;
        sel_data  = '0;
        sel_eop   = 1'b0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (grant_onehot[i]) begin
                sel_wid   = in_wid[i*NW_BITS +: NW_BITS];
                sel_tmask = in_tmask[i*NUM_THREADS +: NUM_THREADS];
                sel_pc    = in_pc[i*PC_BITS +: PC_BITS];
                sel_rd    = in_rd[i*RD_BITS +: RD_BITS];
                sel_data  = in_data[i*LW +: LW];
                sel_eop   = in_eop[i];
            end
        end
    end

    // Heap-ordered adder tree: leaves at LEAVES.., node k sums children 2k and 2k+1.
    always_comb begin
        for (int i = 0; i < LEAVES; i++) begin
            tree[LEAVES+i] = '0;
            if (i < NUM_CHANNELS) begin
                if (cmt_fire[i]) begin
                    tree[LEAVES+i] = CNT_BITS'($countones(in_tmask[i*NUM_THREADS +: NUM_THREADS]));
                end
            end
        end
        for (int k = LEAVES - 1; k >= 1; k--) begin
            tree[k] = tree[2*k] + tree[2*k+1];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_valid  <= 1'b0;
            wb_eop    <= 1'b0;
            cmt_valid <= 1'b0;
            cmt_count <= '0;
        end else begin
            if (pipe_ready) begin
                wb_valid <= grant_fire;
                wb_eop   <= sel_eop;
            end
            cmt_valid <= (tree[1] != '0);
            cmt_count <= tree[1];
        end
    end

    always_ff @(posedge clk) begin
        if (grant_fire) begin
            wb_wid   <= sel_wid;
            wb_tmask <= sel_tmask;
            wb_pc    <= sel_pc;
            wb_rd    <= sel_rd;
            wb_data  <= sel_data;
        end
    end

endmodule

// File: tb/tb_vx_writeback_arbiter.sv
// Directed bench for vx_writeback_arbiter with default parameters (6 channels, 4 lanes).
module tb_vx_writeback_arbiter;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [5:0]   in_valid = '0;
    logic [5:0]   in_wb = 6'h3F;
    logic [11:0]  in_wid = '0;
    logic [23:0]  in_tmask = '0;
    logic [191:0] in_pc = '0;
    logic [29:0]  in_rd = '0;
    logic [767:0] in_data = '0;
    logic [5:0]   in_eop = '0;
    logic [5:0]   in_ready;
    logic         wb_valid;
    logic [1:0]   wb_wid;
    logic [3:0]   wb_tmask;
    logic [31:0]  wb_pc;
    logic [4:0]   wb_rd;
    logic [127:0] wb_data;
    logic         wb_eop;
    logic         wb_ready = 1'b1;
    logic         cmt_valid;
    logic [4:0]   cmt_count;

    int checks = 0;
    int errors = 0;

    vx_writeback_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_wb     (in_wb),
        .in_wid    (in_wid),
        .in_tmask  (in_tmask),
        .in_pc     (in_pc),
        .in_rd     (in_rd),
        .in_data   (in_data),
        .in_eop    (in_eop),
        .in_ready  (in_ready),
        .wb_valid  (wb_valid),
        .wb_wid    (wb_wid),
        .wb_tmask  (wb_tmask),
        .wb_pc     (wb_pc),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .wb_eop    (wb_eop),
        .wb_ready  (wb_ready),
        .cmt_valid (cmt_valid),
        .cmt_count (cmt_count)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] lanes(input logic [31:0] pc);
        return {pc + 32'd3, pc + 32'd2, pc + 32'd1, pc};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic v, input logic wb, input logic eop,
                          input logic [3:0] tm, input logic [31:0] pc);
        in_valid[ch]         = v;
        in_wb[ch]            = wb;
        in_eop[ch]           = eop;
        in_tmask[ch*4 +: 4]  = tm;
        in_pc[ch*32 +: 32]   = pc;
        in_rd[ch*5 +: 5]     = 5'(ch + 1);
        in_wid[ch*2 +: 2]    = 2'(ch);
        in_data[ch*128 +: 128] = lanes(pc);
    endtask

    task automatic test_reset();
        step();
        step();
        set_ch(0, 1'b1, 1'b1, 1'b1, 4'hF, 32'h100);
        #1;
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid: got %b exp 0", wb_valid); end
        checks++; if (cmt_valid !== 1'b0) begin errors++; $display("FAIL reset_cmt_valid: got %b exp 0", cmt_valid); end
        checks++; if (cmt_count !== 5'd0) begin errors++; $display("FAIL reset_cmt_count: got %0d exp 0", cmt_count); end
        checks++; if (in_ready !== 6'b000000) begin errors++; $display("FAIL reset_in_ready: got %b exp 000000", in_ready); end
        in_wb = 6'b111110;
        #1;
        checks++; if (in_ready !== 6'b000001) begin errors++; $display("FAIL reset_nonwb_ready: got %b exp 000001", in_ready); end
        in_wb = 6'h3F;
        set_ch(0, 1'b0, 1'b1, 1'b0, 4'h0, 32'h0);
    endtask

    task automatic test_basic();
        set_ch(0, 1'b1, 1'b1, 1'b1, 4'hF, 32'h100);
        set_ch(2, 1'b1, 1'b1, 1'b1, 4'hF, 32'h300);
        #1;
        checks++; if (in_ready !== 6'b000000) begin errors++; $display("FAIL basic_ready_in_reset: got %b exp 000000", in_ready); end
        reset = 1'b1;
        #1;
        checks++; if (in_ready !== 6'b000001) begin errors++; $display("FAIL basic_ready0: got %b exp 000001", in_ready); end
        step();
        checks++; if (wb_valid !== 1'b1 || wb_pc !== 32'h100) begin errors++; $display("FAIL basic_beat0: got v=%b pc=%h exp v=1 pc=00000100", wb_valid, wb_pc); end
        checks++; if (wb_data !== lanes(32'h100) || wb_rd !== 5'd1 || wb_wid !== 2'd0) begin errors++; $display("FAIL basic_fields0: got data=%h rd=%0d wid=%0d", wb_data, wb_rd, wb_wid); end
        checks++; if (cmt_count !== 5'd4 || cmt_valid !== 1'b1) begin errors++; $display("FAIL basic_cmt0: got %0d/%b exp 4/1", cmt_count, cmt_valid); end
        set_ch(0, 1'b0, 1'b1, 1'b1, 4'hF, 32'h100);
        #1;
        checks++; if (in_ready !== 6'b000100) begin errors++; $display("FAIL basic_ready1: got %b exp 000100", in_ready); end
        step();
        checks++; if (wb_valid !== 1'b1 || wb_pc !== 32'h300 || wb_rd !== 5'd3 || wb_wid !== 2'd2) begin errors++; $display("FAIL basic_beat1: got v=%b pc=%h rd=%0d wid=%0d", wb_valid, wb_pc, wb_rd, wb_wid); end
        // Pointer now 3: channel 4 must win over channel 2.
        set_ch(2, 1'b1, 1'b1, 1'b1, 4'hF, 32'h304);
        set_ch(4, 1'b1, 1'b1, 1'b1, 4'hF, 32'h500);
        #1;
        checks++; if (in_ready !== 6'b010000) begin errors++; $display("FAIL basic_ptr3: got %b exp 010000", in_ready); end
        step();
        checks++; if (wb_pc !== 32'h500) begin errors++; $display("FAIL basic_beat2: got %h exp 00000500", wb_pc); end
        set_ch(2, 1'b0, 1'b1, 1'b0, 4'h0, 32'h0);
        set_ch(4, 1'b0, 1'b1, 1'b0, 4'h0, 32'h0);
        step();
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL basic_drain: got %b exp 0", wb_valid); end
    endtask

    task automatic test_lock();
        set_ch(1, 1'b1, 1'b1, 1'b0, 4'hF, 32'h200);
        set_ch(4, 1'b1, 1'b1, 1'b1, 4'hF, 32'h500);
        #1;
        checks++; if (in_ready !== 6'b000010) begin errors++; $display("FAIL lock_ready0: got %b exp 000010", in_ready); end
        step();
        checks++; if (wb_pc !== 32'h200 || wb_eop !== 1'b0) begin errors++; $display("FAIL lock_beat0: got pc=%h eop=%b exp 00000200/0", wb_pc, wb_eop); end
        checks++; if (cmt_count !== 5'd0) begin errors++; $display("FAIL lock_cmt_noeop: got %0d exp 0", cmt_count); end
        set_ch(1, 1'b1, 1'b1, 1'b0, 4'hF, 32'h204);
        set_ch(0, 1'b1, 1'b1, 1'b1, 4'hF, 32'h100);
        #1;
        checks++; if (in_ready !== 6'b000010) begin errors++; $display("FAIL lock_hold1: got %b exp 000010", in_ready); end
        step();
        checks++; if (wb_pc !== 32'h204) begin errors++; $display("FAIL lock_beat1: got %h exp 00000204", wb_pc); end
        set_ch(1, 1'b1, 1'b1, 1'b1, 4'hF, 32'h208);
        #1;
        checks++; if (in_ready !== 6'b000010) begin errors++; $display("FAIL lock_hold2: got %b exp 000010", in_ready); end
        step();
        checks++; if (wb_pc !== 32'h208 || wb_eop !== 1'b1) begin errors++; $display("FAIL lock_beat2: got pc=%h eop=%b exp 00000208/1", wb_pc, wb_eop); end
        set_ch(1, 1'b0, 1'b1, 1'b0, 4'h0, 32'h0);
        #1;
        checks++; if (in_ready !== 6'b010000) begin errors++; $display("FAIL lock_next_ch4: got %b exp 010000", in_ready); end
        step();
        checks++; if (wb_pc !== 32'h500 || cmt_count !== 5'd4) begin errors++; $display("FAIL lock_ch4: got pc=%h cmt=%0d exp 00000500/4", wb_pc, cmt_count); end
        set_ch(4, 1'b0, 1'b1, 1'b0, 4'h0, 32'h0);
        step();
        checks++; if (wb_pc !== 32'h100) begin errors++; $display("FAIL lock_ch0: got %h exp 00000100", wb_pc); end
        set_ch(0, 1'b0, 1'b1, 1'b0, 4'h0, 32'h0);
        step();
    endtask

    task automatic test_backpressure();
        wb_ready = 1'b0;
        set_ch(3, 1'b1, 1'b1, 1'b1, 4'hF, 32'h400);
        #1;
        checks++; if (in_ready !== 6'b001000) begin errors++; $display("FAIL bp_ready_empty: got %b exp 001000", in_ready); end
        step();
        set_ch(3, 1'b1, 1'b1, 1'b1, 4'hF, 32'h404);
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++; if (wb_valid !== 1'b1 || wb_pc !== 32'h400 || wb_data !== lanes(32'h400)) begin errors++; $display("FAIL bp_hold cycle %0d: got v=%b pc=%h", c, wb_valid, wb_pc); end
            checks++; if (in_ready[3] !== 1'b0) begin errors++; $display("FAIL bp_stall cycle %0d: got %b exp 0", c, in_ready[3]); end
            step();
        end
        wb_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 6'b001000) begin errors++; $display("FAIL bp_release_ready: got %b exp 001000", in_ready); end
        step();
        checks++; if (wb_valid !== 1'b1 || wb_pc !== 32'h404) begin errors++; $display("FAIL bp_second: got v=%b pc=%h exp 1/00000404", wb_valid, wb_pc); end
        set_ch(3, 1'b0, 1'b1, 1'b0, 4'h0, 32'h0);
        step();
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b exp 0", wb_valid); end
    endtask

    task automatic test_commit_count();
        for (int c = 0; c < 6; c++) set_ch(c, 1'b1, 1'b0, 1'b1, 4'hF, 32'(c * 256));
        #1;
        checks++; if (in_ready !== 6'b111111) begin errors++; $display("FAIL cmt_all_ready: got %b exp 111111", in_ready); end
        step();
        checks++; if (cmt_count !== 5'd24 || cmt_valid !== 1'b1) begin errors++; $display("FAIL cmt_all: got %0d/%b exp 24/1", cmt_count, cmt_valid); end
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL cmt_no_wb: got %b exp 0", wb_valid); end
        for (int c = 0; c < 6; c++) set_ch(c, 1'b0, 1'b1, 1'b0, 4'h0, 32'h0);
        step();
        checks++; if (cmt_count !== 5'd0 || cmt_valid !== 1'b0) begin errors++; $display("FAIL cmt_idle: got %0d/%b exp 0/0", cmt_count, cmt_valid); end
    endtask

    task automatic test_zero_tmask();
        set_ch(2, 1'b1, 1'b1, 1'b1, 4'h0, 32'h300);
        set_ch(0, 1'b1, 1'b0, 1'b1, 4'b0101, 32'h100);
        #1;
        checks++; if (in_ready !== 6'b000101) begin errors++; $display("FAIL zt_ready: got %b exp 000101", in_ready); end
        step();
        checks++; if (wb_valid !== 1'b1 || wb_tmask !== 4'h0 || wb_pc !== 32'h300) begin errors++; $display("FAIL zt_pass: got v=%b tm=%h pc=%h", wb_valid, wb_tmask, wb_pc); end
        checks++; if (cmt_count !== 5'd2 || cmt_valid !== 1'b1) begin errors++; $display("FAIL zt_cmt: got %0d/%b exp 2/1", cmt_count, cmt_valid); end
        set_ch(2, 1'b0, 1'b1, 1'b0, 4'h0, 32'h0);
        set_ch(0, 1'b0, 1'b1, 1'b0, 4'h0, 32'h0);
        step();
    endtask

    task automatic test_wrap();
        set_ch(5, 1'b1, 1'b1, 1'b1, 4'hF, 32'h600);
        set_ch(2, 1'b1, 1'b1, 1'b1, 4'hF, 32'h300);
        #1;
        checks++; if (in_ready !== 6'b100000) begin errors++; $display("FAIL wrap_ready5: got %b exp 100000", in_ready); end
        step();
        checks++; if (wb_pc !== 32'h600) begin errors++; $display("FAIL wrap_beat5: got %h exp 00000600", wb_pc); end
        set_ch(5, 1'b0, 1'b1, 1'b0, 4'h0, 32'h0);
        set_ch(0, 1'b1, 1'b1, 1'b1, 4'hF, 32'h100);
        #1;
        checks++; if (in_ready !== 6'b000001) begin errors++; $display("FAIL wrap_ptr0: got %b exp 000001", in_ready); end
        step();
        checks++; if (wb_pc !== 32'h100) begin errors++; $display("FAIL wrap_beat0: got %h exp 00000100", wb_pc); end
        set_ch(0, 1'b0, 1'b1, 1'b0, 4'h0, 32'h0);
        set_ch(2, 1'b0, 1'b1, 1'b0, 4'h0, 32'h0);
        step();
    endtask

    task automatic test_reset_mid_packet();
        set_ch(5, 1'b1, 1'b1, 1'b0, 4'hF, 32'h600);
        step();
        checks++; if (wb_valid !== 1'b1 || wb_eop !== 1'b0) begin errors++; $display("FAIL rmp_first: got v=%b eop=%b exp 1/0", wb_valid, wb_eop); end
        set_ch(5, 1'b1, 1'b1, 1'b0, 4'hF, 32'h604);
        set_ch(0, 1'b1, 1'b1, 1'b1, 4'hF, 32'h100);
        reset = 1'b0;
        #1;
        checks++; if (wb_valid !== 1'b0 || in_ready !== 6'b000000) begin errors++; $display("FAIL rmp_async: got v=%b rdy=%b exp 0/000000", wb_valid, in_ready); end
        step();
        reset = 1'b1;
        #1;
        checks++; if (in_ready !== 6'b000001) begin errors++; $display("FAIL rmp_grant0: got %b exp 000001", in_ready); end
        step();
        checks++; if (wb_valid !== 1'b1 || wb_pc !== 32'h100) begin errors++; $display("FAIL rmp_beat0: got v=%b pc=%h exp 1/00000100", wb_valid, wb_pc); end
        set_ch(0, 1'b0, 1'b1, 1'b0, 4'h0, 32'h0);
        set_ch(5, 1'b0, 1'b1, 1'b0, 4'h0, 32'h0);
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_lock();
        test_backpressure();
        test_commit_count();
        test_zero_tmask();
        test_wrap();
        test_reset_mid_packet();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
